puf_challenge_driver: RTL and testbench
=======================================

Name: puf_challenge_driver

Overview:
- Initiator side of the PUF challenge/response interface: generates 32-bit challenges, drives them into the 4-arbiter PUF array, waits for the arbiters to settle, and samples the 4-bit MKG response REPEATS times.
- Majority-votes each response bit, flags unstable bits, and emits the challenge/response pair (CRP) over a valid/ready stream to the enrollment/authentication logic.

Parameters:
- SETTLE_CYCLES, 4, cycles waited after a challenge is applied and between samples; must be >= 1.
- REPEATS, 5, samples per challenge; must be odd and >= 1.
- NUM_CRP, 16, CRPs per start command; 0 = run continuously until reset.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- seed_load  in  1  loads seed into LFSR; honoured only in IDLE.
- seed  in  32  LFSR seed value.
- start  in  1  begins a CRP run; honoured only in IDLE.
- challenge  out  32  challenge bits driven to the PUF array.
- resp  in  4  MKG gate outputs {mkg4,mkg3,mkg2,mkg1}.
- rsp_valid  out  1  CRP available.
- rsp_ready  in  1  consumer accepts CRP.
- rsp_challenge  out  32  challenge of the presented CRP.
- rsp_data  out  4  majority-voted response.
- rsp_unstable  out  4  per-bit flag, set when samples disagreed.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE; LFSR = 0x00000001; challenge, rsp_challenge = 0; rsp_data, rsp_unstable = 0; rsp_valid = 0; busy = 0; all counters = 0.
- LFSR: Fibonacci, taps 32,22,2,1. next = {c[30:0], c[31]^c[21]^c[1]^c[0]}. A seed of 0 loads 0x00000001 instead. seed_load and start asserted in the same IDLE cycle: the seed loads first, and the run uses the new seed.
- IDLE: on start go to APPLY, clear crp_cnt. start outside IDLE is ignored.
- APPLY (1 cycle): challenge <= LFSR value; clear the vote counters and sample counter; go to SETTLE.
- SETTLE: wait SETTLE_CYCLES cycles with challenge held stable; go to SAMPLE.
- SAMPLE (1 cycle): for each bit i, ones[i] += resp[i]; samp_cnt++. If samp_cnt < REPEATS, go back to SETTLE; otherwise go to VOTE.
- VOTE (1 cycle):
  - rsp_data[i] = (ones[i] > REPEATS/2).
  - rsp_unstable[i] = (ones[i] != 0 && ones[i] != REPEATS).
  - rsp_challenge = challenge; rsp_valid <= 1; go to OUTPUT.
- OUTPUT: hold rsp_valid and all rsp_* stable until rsp_ready. On handshake:
  - rsp_valid <= 0, crp_cnt++, LFSR advances one step.
  - If NUM_CRP != 0 and crp_cnt reaches NUM_CRP, go to IDLE; otherwise go to APPLY.
- rsp_ready while rsp_valid is low has no effect. rsp_ready held high costs no extra cycles.
- Counter widths: ones[] and samp_cnt are $clog2(REPEATS+1) bits; crp_cnt is 16 bits and wraps when NUM_CRP = 0.
- Per-CRP latency from APPLY to rsp_valid: 1 + REPEATS*(SETTLE_CYCLES+1) + 1 cycles (27 at defaults).
- Reset mid-run: immediate return to reset values, and any partial CRP is discarded.

Optional Feature:
- Macro PUF_DRV_STATS_EN.
- Defined: adds output stat_unstable_cnt[15:0]. It adds popcount(rsp_unstable) on each handshake, saturates at 0xFFFF, clears on reset, and clears on start accepted in IDLE.
- Undefined: the port and the counter logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package puf_drv_pkg holds:
  - state enum {IDLE, APPLY, SETTLE, SAMPLE, VOTE, OUTPUT};
  - CHAL_W = 32, RESP_W = 4;
  - LFSR tap constants;
  - LFSR_RESET = 32'h00000001.
- Sub-module puf_lfsr32 owns the LFSR: load, zero-seed substitution, and step enable.

Test Plan:
- Reset, no start -> all outputs 0, busy 0, challenge 0x00000000.
- Default seed, start, resp constant 4'b1010, rsp_ready = 1 -> first CRP rsp_challenge 0x00000001, rsp_data 1010, rsp_unstable 0000, rsp_valid asserted 27 cycles after APPLY. Second CRP challenge 0x00000003, third 0x00000006. busy drops after 16 CRPs.
- seed_load with seed 0 then start -> first challenge 0x00000001. seed 0x80000000 -> second challenge 0x00000001 (fb = 1).
- resp bit0 sampled as 1,1,0,1,0 -> rsp_data[0] = 1, rsp_unstable[0] = 1. resp bit1 sampled as 0,1,0,0,0 -> rsp_data[1] = 0, rsp_unstable[1] = 1.
- rsp_ready low for 10 cycles in OUTPUT -> rsp_valid and data stable throughout, LFSR unchanged. On ready, exactly one CRP is counted.
- rst asserted during SETTLE of CRP 3, then start after release -> run restarts from 0x00000001 and the partial CRP is never emitted. With PUF_DRV_STATS_EN, stat_unstable_cnt is 0.

Source files
------------

// File: rtl/puf_drv_pkg.sv
// Shared types and constants for the PUF challenge driver: FSM states,
// bus widths and the 32-bit Fibonacci LFSR (taps 32,22,2,1).
package puf_drv_pkg;

    localparam int CHAL_W = 32;
    localparam int RESP_W = 4;

    // Bit positions 31, 21, 1 and 0 feed the XOR feedback.
    localparam logic [CHAL_W-1:0] LFSR_TAPS  = 32'h8020_0003;
    localparam logic [CHAL_W-1:0] LFSR_RESET = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        VOTE   = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] c);
        return {c[CHAL_W-2:0], ^(c & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/puf_lfsr32.sv
// Challenge generator LFSR: seed load with zero-seed substitution and
// single-step advance; load wins over step.
module puf_lfsr32
    import puf_drv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [CHAL_W-1:0] seed,
    output logic [CHAL_W-1:0] value
);

    // An all-zero state would lock the LFSR, so a zero seed becomes 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= LFSR_RESET;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_RESET : seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/puf_challenge_driver.sv
// Drives LFSR challenges into the arbiter PUF, majority-votes REPEATS samples
// per bit and streams CRPs out. Optional PUF_DRV_STATS_EN adds stat_unstable_cnt.
module puf_challenge_driver
    import puf_drv_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int REPEATS       = 5,
    parameter int NUM_CRP       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              seed_load,
    input  logic [CHAL_W-1:0] seed,
    input  logic              start,
    output logic [CHAL_W-1:0] challenge,
    input  logic [RESP_W-1:0] resp,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CHAL_W-1:0] rsp_challenge,
    output logic [RESP_W-1:0] rsp_data,
    output logic [RESP_W-1:0] rsp_unstable,
    output logic              busy,
`ifdef PUF_DRV_STATS_EN
    output logic [15:0]       stat_unstable_cnt,
`endif
    output logic [2:0]        dbg_state
);

    // Stream handshake: a CRP transfers on a rising edge where rsp_valid and
    // rsp_ready are both high; once raised, rsp_valid and rsp_* hold until then.

    localparam int CW = $clog2(REPEATS + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] HALF = CW'(REPEATS / 2);
    localparam logic [CW-1:0] FULL = CW'(REPEATS);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    state_t            state, state_nxt;
    logic [CHAL_W-1:0] lfsr_value;
    logic              lfsr_load, lfsr_step, hs;
    logic [CW-1:0]     ones [RESP_W];
    logic [CW-1:0]     samp_cnt, samp_inc;
    logic [SW-1:0]     settle_cnt;
    logic [15:0]       crp_cnt;
    logic              last_crp;

    puf_lfsr32 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (seed),
        .value (lfsr_value)
    );

    assign samp_inc  = samp_cnt + 1'b1;
    assign last_crp  = (NUM_CRP != 0) && (crp_cnt == 16'(NUM_CRP - 1));
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        hs        = 1'b0;
        case (state)
            IDLE: begin
                lfsr_load = seed_load;
                if (start) state_nxt = APPLY;
            end
            APPLY:  state_nxt = SETTLE;
            SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
            SAMPLE: state_nxt = (samp_inc < FULL) ? SETTLE : VOTE;
            VOTE:   state_nxt = OUTPUT;
            OUTPUT: begin
                if (rsp_ready) begin
                    hs        = 1'b1;
                    lfsr_step = 1'b1;
                    state_nxt = last_crp ? IDLE : APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            challenge     <= '0;
            rsp_challenge <= '0;
            rsp_data      <= '0;
            rsp_unstable  <= '0;
            rsp_valid     <= 1'b0;
            samp_cnt      <= '0;
            settle_cnt    <= '0;
            crp_cnt       <= '0;
            for (int i = 0; i < RESP_W; i++) ones[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) crp_cnt <= '0;
                APPLY: begin
                    challenge  <= lfsr_value;
                    samp_cnt   <= '0;
                    settle_cnt <= '0;
                    for (int i = 0; i < RESP_W; i++) ones[i] <= '0;
                end
                SETTLE: settle_cnt <= settle_cnt + 1'b1;
                SAMPLE: begin
                    samp_cnt   <= samp_inc;
                    settle_cnt <= '0;
                    for (int i = 0; i < RESP_W; i++) ones[i] <= ones[i] + CW'(resp[i]);
                end
                VOTE: begin
                    // A bit is unstable unless every sample agreed.
                    for (int i = 0; i < RESP_W; i++) begin
                        rsp_data[i]     <= (ones[i] > HALF);
                        rsp_unstable[i] <= (ones[i] != '0) && (ones[i] != FULL);
                    end
                    rsp_challenge <= challenge;
                    rsp_valid     <= 1'b1;
                end
                OUTPUT: begin
                    if (hs) begin
                        rsp_valid <= 1'b0;
                        crp_cnt   <= crp_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PUF_DRV_STATS_EN
    logic [16:0] stat_sum;
    assign stat_sum = {1'b0, stat_unstable_cnt} + 17'($countones(rsp_unstable));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_unstable_cnt <= '0;
        end else if (state == IDLE && start) begin
            stat_unstable_cnt <= '0;
        end else if (hs) begin
            stat_unstable_cnt <= stat_sum[16] ? 16'hFFFF : stat_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Directed self-checking bench for puf_challenge_driver at default parameters;
// also checks stat_unstable_cnt when built with PUF_DRV_STATS_EN.
module tb_puf_challenge_driver;
    import puf_drv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic        start = 1'b0;
    logic [3:0]  resp = '0;
    logic        rsp_ready = 1'b0;
    logic [31:0] challenge, rsp_challenge;
    logic [3:0]  rsp_data, rsp_unstable;
    logic        rsp_valid, busy;
    logic [2:0]  dbg_state;
`ifdef PUF_DRV_STATS_EN
    logic [15:0] stat_unstable_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    puf_challenge_driver dut (
        .clk           (clk),
        .rst           (rst),
        .seed_load     (seed_load),
        .seed          (seed),
        .start         (start),
        .challenge     (challenge),
        .resp          (resp),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_challenge (rsp_challenge),
        .rsp_data      (rsp_data),
        .rsp_unstable  (rsp_unstable),
        .busy          (busy),
`ifdef PUF_DRV_STATS_EN
        .stat_unstable_cnt (stat_unstable_cnt),
`endif
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] model_step(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    // Driver tasks
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        seed_load = 1'b0;
        start = 1'b0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (rsp_valid !== 1'b1 && cyc < 200);
    endtask

    task automatic wait_state(input logic [2:0] st, output int cyc);
        cyc = 0;
        while (dbg_state !== st && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Scenarios
    task automatic test_reset();
        do_reset();
        repeat (5) @(negedge clk);
        n_tests++; if (challenge !== 32'h0) begin n_fail++; $display("FAIL reset_challenge: got %h expected %h", challenge, 32'h0); end
        n_tests++; if (rsp_challenge !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_challenge: got %h expected %h", rsp_challenge, 32'h0); end
        n_tests++; if (rsp_data !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %b expected %b", rsp_data, 4'h0); end
        n_tests++; if (rsp_unstable !== 4'h0) begin n_fail++; $display("FAIL reset_rsp_unstable: got %b expected %b", rsp_unstable, 4'h0); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
`ifdef PUF_DRV_STATS_EN
        n_tests++; if (stat_unstable_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_stat: got %h expected 0", stat_unstable_cnt); end
`endif
    endtask

    task automatic test_default_run();
        int cyc;
        logic [31:0] m;
        logic [31:0] exp_c;
        do_reset();
        resp = 4'b1010;
        rsp_ready = 1'b1;
        m = 32'h1;
        exp_q.delete();
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(m);
            m = model_step(m);
        end
        pulse_start();
        for (int k = 0; k < 16; k++) begin
            wait_valid(cyc);
            n_tests++;
            if (cyc !== ((k == 0) ? 27 : 28)) begin
                n_fail++; $display("FAIL run_latency[%0d]: got %0d expected %0d", k, cyc, (k == 0) ? 27 : 28);
            end
            exp_c = exp_q.pop_front();
            n_tests++; if (rsp_challenge !== exp_c) begin n_fail++; $display("FAIL run_challenge[%0d]: got %h expected %h", k, rsp_challenge, exp_c); end
            n_tests++; if (rsp_data !== 4'b1010) begin n_fail++; $display("FAIL run_data[%0d]: got %b expected 1010", k, rsp_data); end
            n_tests++; if (rsp_unstable !== 4'b0000) begin n_fail++; $display("FAIL run_unstable[%0d]: got %b expected 0000", k, rsp_unstable); end
            n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy[%0d]: got %b expected 1", k, busy); end
            if (k == 1) begin
                n_tests++; if (rsp_challenge !== 32'h3) begin n_fail++; $display("FAIL run_second_chal: got %h expected 00000003", rsp_challenge); end
            end
            if (k == 2) begin
                n_tests++; if (rsp_challenge !== 32'h6) begin n_fail++; $display("FAIL run_third_chal: got %h expected 00000006", rsp_challenge); end
            end
        end
        @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_done_busy: got %b expected 0", busy); end
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL run_done_valid: got %b expected 0", rsp_valid); end
        repeat (30) @(negedge clk);
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_stays_idle: got %b expected 0", busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_seed();
        int cyc;
        do_reset();
        rsp_ready = 1'b1;
        seed_load = 1'b1; seed = 32'hDEAD_BEEF;
        @(negedge clk);
        seed = 32'h0;
        @(negedge clk);
        seed_load = 1'b0;
        pulse_start();
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h1) begin n_fail++; $display("FAIL seed_zero: got %h expected 00000001", rsp_challenge); end

        do_reset();
        rsp_ready = 1'b1;
        seed = 32'h8000_0000;
        seed_load = 1'b1;
        start = 1'b1;
        @(negedge clk);
        seed_load = 1'b0;
        start = 1'b0;
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h8000_0000) begin n_fail++; $display("FAIL seed_msb_first: got %h expected 80000000", rsp_challenge); end
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h1) begin n_fail++; $display("FAIL seed_msb_second: got %h expected 00000001", rsp_challenge); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_majority();
        int cyc;
        logic [3:0] samp [5];
        samp[0] = 4'b0101; samp[1] = 4'b0111; samp[2] = 4'b0100;
        samp[3] = 4'b0101; samp[4] = 4'b0100;
        do_reset();
        rsp_ready = 1'b0;
        resp = samp[0];
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            wait_state(SAMPLE, cyc);
            n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL maj_sample_wait[%0d]: got timeout expected SAMPLE", k); end
            @(negedge clk);
            if (k < 4) resp = samp[k + 1];
        end
        wait_valid(cyc);
        n_tests++; if (rsp_data !== 4'b0101) begin n_fail++; $display("FAIL maj_data: got %b expected 0101", rsp_data); end
        n_tests++; if (rsp_unstable !== 4'b0011) begin n_fail++; $display("FAIL maj_unstable: got %b expected 0011", rsp_unstable); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
`ifdef PUF_DRV_STATS_EN
        n_tests++; if (stat_unstable_cnt !== 16'd2) begin n_fail++; $display("FAIL maj_stat: got %0d expected 2", stat_unstable_cnt); end
`endif
    endtask

    task automatic test_backpressure();
        int cyc;
        do_reset();
        rsp_ready = 1'b0;
        resp = 4'b0110;
        pulse_start();
        wait_valid(cyc);
        n_tests++; if (cyc !== 27) begin n_fail++; $display("FAIL bp_latency: got %0d expected 27", cyc); end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_tests++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b expected 1", k, rsp_valid); end
            n_tests++; if (rsp_challenge !== 32'h1 || challenge !== 32'h1) begin n_fail++; $display("FAIL bp_chal[%0d]: got %h/%h expected 00000001", k, rsp_challenge, challenge); end
            n_tests++; if (rsp_data !== 4'b0110 || rsp_unstable !== 4'b0000) begin n_fail++; $display("FAIL bp_data[%0d]: got %b/%b expected 0110/0000", k, rsp_data, rsp_unstable); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drop: got %b expected 0", rsp_valid); end
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h3) begin n_fail++; $display("FAIL bp_next_chal: got %h expected 00000003", rsp_challenge); end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        int seen;
        do_reset();
        rsp_ready = 1'b1;
        resp = 4'b1111;
        pulse_start();
        wait_valid(cyc);
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h3) begin n_fail++; $display("FAIL mid_second: got %h expected 00000003", rsp_challenge); end
        @(negedge clk);
        wait_state(SETTLE, cyc);
        n_tests++; if (cyc >= 200) begin n_fail++; $display("FAIL mid_settle_wait: got timeout expected SETTLE"); end
        n_tests++; if (challenge !== 32'h6) begin n_fail++; $display("FAIL mid_third_applied: got %h expected 00000006", challenge); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_tests++; if (challenge !== 32'h0 || rsp_challenge !== 32'h0) begin n_fail++; $display("FAIL mid_rst_chal: got %h/%h expected 0/0", challenge, rsp_challenge); end
        n_tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got valid %b busy %b expected 0 0", rsp_valid, busy); end
        n_tests++; if (rsp_data !== 4'h0 || rsp_unstable !== 4'h0) begin n_fail++; $display("FAIL mid_rst_rsp: got %b/%b expected 0000/0000", rsp_data, rsp_unstable); end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
        end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL mid_no_partial: got %0d valid cycles expected 0", seen); end
        pulse_start();
        wait_valid(cyc);
        n_tests++; if (rsp_challenge !== 32'h1) begin n_fail++; $display("FAIL mid_restart: got %h expected 00000001", rsp_challenge); end
`ifdef PUF_DRV_STATS_EN
        n_tests++; if (stat_unstable_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_stat: got %0d expected 0", stat_unstable_cnt); end
`endif
        rsp_ready = 1'b0;
    endtask

    // Sequence and final report
    initial begin
        test_reset();
        test_default_run();
        test_seed();
        test_majority();
        test_backpressure();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
